// File: rtl/caleidoscope_gen.sv
// caleidoscope_gen: mirrored-quadrant pattern generator with a 4-stage
// colour pipeline and a frame-rate animation sequencer.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   SEQ_IDLE | no update pending; TT and TC hold
//   SEQ_TT   | frame time just changed; recompute the triangle value TT
//   SEQ_TC   | TT just changed; recompute the colour offset TC
module caleidoscope_gen #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int X_W    = 10,
  parameter int Y_W    = 9,
  parameter int R_BITS = 3,
  parameter int G_BITS = 3,
  parameter int B_BITS = 2,
  parameter int TIME_W = 16
) (
  input  logic                             CLK_25MHz,
  input  logic                             RESET,
  input  logic [X_W-1:0]                   CURX,
  input  logic [Y_W-1:0]                   CURY,
  input  logic                             DE,
  input  logic                             VBLANK,
  input  logic [1:0]                       SPEED,
  input  logic                             STOP,
  input  logic                             REVERSE,
  input  logic [1:0]                       MIRROR,
  output logic [R_BITS+G_BITS+B_BITS-1:0]  COLOR_OUT,
  output logic                             DE_OUT,
  output logic [TIME_W-1:0]                FRAME_TIME
);

  localparam int CW   = R_BITS + G_BITS + B_BITS;
  localparam int YS_W = 2 * Y_W;

  localparam logic [X_W-1:0] X_HALF = X_W'(H_RES / 2);
  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_HALF = Y_W'(V_RES / 2);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);
  localparam logic [23:0]    TC_BASE = 24'h000200;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_TT   = 2'd1,
    SEQ_TC   = 2'd2
  } seq_state_t;

  seq_state_t        seq_state;
  logic              vb_q;
  logic              vb_rise;
  logic [TIME_W-1:0] frame_time_q;
  logic [TIME_W-1:0] time_step;
  logic [7:0]        tt_q;
  logic [23:0]       tc_q;

  // fold results
  logic [X_W-1:0]    fx;
  logic [Y_W-1:0]    fy;

  // stage 1
  logic              s1_v;
  logic [X_W-1:0]    s1_fx;
  logic [Y_W-1:0]    s1_fy;

  // stage 2
  logic              s2_v;
  logic [X_W-1:0]    s2_xr;
  logic [YS_W-1:0]   s2_ys;
  logic [23:0]       s2_s;

  // stage 3
  logic              s3_v;
  logic [31:0]       s3_acc;

  // stage 4 combinational colour map
  logic [1:0]        sel;
  logic [7:0]        p;
  logic [7:0]        pt;
  logic [R_BITS-1:0] col_r;
  logic [G_BITS-1:0] col_g;
  logic [B_BITS-1:0] col_b;
  logic [CW-1:0]     col;

  // Accumulator bits outside the SEL/P window and the low PT bits are
  // architecturally computed but not consumed by the colour map.
  logic              unused_bits;
  assign unused_bits = ^{s3_acc[31:18], s3_acc[7:0], pt};

  assign vb_rise    = VBLANK & ~vb_q;
  assign time_step  = TIME_W'(SPEED) + TIME_W'(1);
  assign FRAME_TIME = frame_time_q;

  // Frame sequencer: step the frame time on a VBLANK rise, then derive TT, then TC.
  always_ff @(posedge CLK_25MHz) begin
    if (RESET) begin
      vb_q         <= 1'b0;
      seq_state    <= SEQ_IDLE;
      frame_time_q <= '0;
      tt_q         <= 8'h00;
      tc_q         <= TC_BASE;
    end else begin
      vb_q <= VBLANK;
      if (vb_rise) begin
        // a rise during a pending update restarts the sequence
        if (!STOP) begin
          frame_time_q <= REVERSE ? (frame_time_q - time_step)
                                  : (frame_time_q + time_step);
        end
        seq_state <= SEQ_TT;
      end else begin
        case (seq_state)
          SEQ_TT: begin
            tt_q      <= frame_time_q[7] ? (8'hFF - frame_time_q[7:0]) : frame_time_q[7:0];
            seq_state <= SEQ_TC;
          end
          SEQ_TC: begin
            tc_q      <= TC_BASE - {13'd0, tt_q, 3'd0};
            seq_state <= SEQ_IDLE;
          end
          default: seq_state <= SEQ_IDLE;
        endcase
      end
    end
  end

  // Quadrant fold: the upper half of each enabled axis is mirrored back.
  always_comb begin
    fx = CURX;
    fy = CURY;
    if (MIRROR[0] && (CURX >= X_HALF)) fx = X_LAST - CURX;
    if (MIRROR[1] && (CURY >= Y_HALF)) fy = Y_LAST - CURY;
  end

  // Stage 1: capture folded coordinates.
  always_ff @(posedge CLK_25MHz) begin
    if (RESET) begin
      s1_v  <= 1'b0;
      s1_fx <= '0;
      s1_fy <= '0;
    end else begin
      s1_v  <= DE;
      s1_fx <= fx;
      s1_fy <= fy;
    end
  end

  // Stage 2: XOR pattern, Y square and time-offset sum.
  always_ff @(posedge CLK_25MHz) begin
    if (RESET) begin
      s2_v  <= 1'b0;
      s2_xr <= '0;
      s2_ys <= '0;
      s2_s  <= '0;
    end else begin
      s2_v  <= s1_v;
      s2_xr <= s1_fx ^ X_W'(s1_fy);
      s2_ys <= YS_W'(s1_fy) * YS_W'(s1_fy);
      s2_s  <= tc_q + 24'(s1_fx ^ X_W'(s1_fy));
    end
  end

  // Stage 3: multiply-accumulate, modulo 2^32.
  always_ff @(posedge CLK_25MHz) begin
    if (RESET) begin
      s3_v   <= 1'b0;
      s3_acc <= '0;
    end else begin
      s3_v   <= s2_v;
      s3_acc <= (32'(s2_s) * 32'(s2_xr)) + 32'(s2_ys);
    end
  end

  // Stage 4 colour map: SEL picks the lit channel(s), PT is P folded to 0..0x7F.
  always_comb begin
    sel   = s3_acc[17:16];
    p     = s3_acc[15:8];
    pt    = p[7] ? (8'hFF - p) : p;
    col_r = '0;
    col_g = '0;
    col_b = '0;
    case (sel)
      2'd0: col_r = pt[6 -: R_BITS];
      2'd1: col_g = pt[6 -: G_BITS];
      2'd2: col_b = pt[6 -: B_BITS];
      default: begin
        col_r = pt[6 -: R_BITS];
        col_g = pt[6 -: G_BITS];
        col_b = pt[6 -: B_BITS];
      end
    endcase
    col = {col_r, col_g, col_b};
  end

  // Stage 4 output register; blanked pixels are forced to black.
  always_ff @(posedge CLK_25MHz) begin
    if (RESET) begin
      DE_OUT    <= 1'b0;
      COLOR_OUT <= '0;
    end else begin
      DE_OUT    <= s3_v;
      COLOR_OUT <= s3_v ? col : '0;
    end
  end

endmodule
